// File: rtl/core_types_pkg.sv
// Shared core types for the fetch/predict front end.
// Holds the return-address-stack sizing constants, the snapshot record that
// fetch attaches to each branch (and that the ROB hands back on a
// mispredict), and the RAS per-cycle operation encoding.
package core_types_pkg;

  localparam int RAS_ENTRIES      = 8;
  localparam int RAS_TARGET_WIDTH = 31;
  localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
  localparam int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES + 1);

  // Snapshot carried with each predicted branch; restoring it rewinds the RAS.
  typedef struct packed {
    logic [RAS_INDEX_WIDTH-1:0] index;
    logic [RAS_COUNT_WIDTH-1:0] count;
  } ras_snapshot_t;

  // Resolved per-cycle action, in priority order restore > swap > push > pop.
  typedef enum logic [2:0] {
    RAS_OP_NONE,
    RAS_OP_RESTORE,
    RAS_OP_SWAP,
    RAS_OP_PUSH,
    RAS_OP_POP
  } ras_op_e;

endpackage

// File: rtl/ras_ckpt.sv
// Return address stack with snapshot restore for the fetch predictor.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   push_valid/target   call: push a return target
//   pop_valid           return: pop the top entry
//   restore_valid/index/count  mispredict: rewind top pointer and occupancy
//   ras_ret_target      entry[top], combinational
//   ras_index/count     current top pointer and occupancy (the snapshot)
//   ras_empty           occupancy is zero
//   ras_overflow        1-cycle pulse after a push while full
//   ras_underflow       1-cycle pulse after a pop while empty
// The stack is circular and depth need not be a power of two, so the top
// pointer wraps explicitly rather than by natural overflow.
module ras_ckpt #(
  parameter int RAS_ENTRIES      = core_types_pkg::RAS_ENTRIES,
  parameter int RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH,
  parameter int OVERFLOW_WRAP    = 1,
  parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
  parameter int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES + 1)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  input  logic                        restore_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
  input  logic [RAS_COUNT_WIDTH-1:0]  restore_count,
  output logic [RAS_TARGET_WIDTH-1:0] ras_ret_target,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
  output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
  output logic                        ras_empty,
  output logic                        ras_overflow,
  output logic                        ras_underflow
);

  logic [RAS_TARGET_WIDTH-1:0] entries [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0]  top, top_n, wr_idx;
  logic [RAS_COUNT_WIDTH-1:0]  count, count_n;
  logic [RAS_TARGET_WIDTH-1:0] wr_data;
  logic                        wr_en, ovf, ovf_n, unf, unf_n, full;
  core_types_pkg::ras_op_e     op;

  function automatic logic [RAS_INDEX_WIDTH-1:0] inc(input logic [RAS_INDEX_WIDTH-1:0] i);
    return (int'(i) == RAS_ENTRIES - 1) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [RAS_INDEX_WIDTH-1:0] dec(input logic [RAS_INDEX_WIDTH-1:0] i);
    return (i == '0) ? RAS_INDEX_WIDTH'(RAS_ENTRIES - 1) : i - 1'b1;
  endfunction

  assign full = (int'(count) == RAS_ENTRIES);

  always_comb begin
    op = core_types_pkg::RAS_OP_NONE;
    if (restore_valid)              op = core_types_pkg::RAS_OP_RESTORE;
    else if (push_valid && pop_valid) op = core_types_pkg::RAS_OP_SWAP;
    else if (push_valid)            op = core_types_pkg::RAS_OP_PUSH;
    else if (pop_valid)             op = core_types_pkg::RAS_OP_POP;
  end

  always_comb begin
    top_n   = top;
    count_n = count;
    wr_en   = 1'b0;
    wr_idx  = top;
    wr_data = push_target;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;
    unique case (op)
      core_types_pkg::RAS_OP_RESTORE: begin
        top_n   = restore_index;
        count_n = restore_count;
      end
      // Tail call: replace the current return target in place.
      core_types_pkg::RAS_OP_SWAP: wr_en = 1'b1;
      core_types_pkg::RAS_OP_PUSH: begin
        ovf_n = full;
        // When wrapping on a full stack the write lands on the oldest entry.
        if (!full || OVERFLOW_WRAP != 0) begin
          top_n  = inc(top);
          wr_idx = inc(top);
          wr_en  = 1'b1;
          if (!full) count_n = count + 1'b1;
        end
      end
      // The pointer moves even when empty so stale targets keep predicting.
      core_types_pkg::RAS_OP_POP: begin
        top_n = dec(top);
        if (count != '0) count_n = count - 1'b1;
        else             unf_n   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      top   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      for (int i = 0; i < RAS_ENTRIES; i++) entries[i] <= '0;
    end else begin
      top   <= top_n;
      count <= count_n;
      ovf   <= ovf_n;
      unf   <= unf_n;
      if (wr_en) entries[wr_idx] <= wr_data;
    end
  end

  assign ras_ret_target = entries[top];
  assign ras_index      = top;
  assign ras_count      = count;
  assign ras_empty      = (count == '0);
  assign ras_overflow   = ovf;
  assign ras_underflow  = unf;

  restore_legal: assert property (@(posedge CLK) disable iff (RST)
    restore_valid |-> (int'(restore_index) < RAS_ENTRIES && int'(restore_count) <= RAS_ENTRIES));

endmodule
